// File: rtl/sdm_pkg.sv
// Shared constants and types for the fractional-N delta-sigma modulator
// and the multi-modulus divider that consumes its offset.
package sdm_pkg;

  localparam int ACC_W_DEFAULT  = 16;
  localparam int LFSR_W_DEFAULT = 15;
  // Polynomial x^W + x^(W-1) + 1: feedback taps are the two top bits.
  localparam int LFSR_TAP_HI    = 1;  // offset from MSB of first tap
  localparam int LFSR_SEED      = 1;
  localparam int OFFSET_W       = 4;

  typedef logic signed [OFFSET_W-1:0] offset_t;

  // Widen a single carry bit into the signed offset domain.
  function automatic offset_t carry_to_offset(input logic c);
    return offset_t'({{(OFFSET_W-1){1'b0}}, c});
  endfunction

endpackage

// File: rtl/sdm_acc_stage.sv
// One accumulator stage: registered W-bit accumulator plus addend and
// carry-in. Exposes the wrapped sum (feeds the next stage) and carry out.
module sdm_acc_stage #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic [W-1:0] addend_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         carry_o
);

  logic [W-1:0] acc_q;
  logic [W:0]   sum_full;

  assign sum_full = {1'b0, acc_q} + {1'b0, addend_i} + {{W{1'b0}}, cin_i};
  assign sum_o    = sum_full[W-1:0];
  assign carry_o  = sum_full[W];

  // Accumulator register: synchronous clear wins over enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (clr_i) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= sum_full[W-1:0];
    end
  end

endmodule

// File: rtl/frac_n_sdm.sv
// Fractional-N delta-sigma modulator: first-order or MASH 1-1-1 with
// optional LFSR dither. Produces the divider modulus select (x) and a
// signed multi-modulus offset. Clocked by the divider output.
module frac_n_sdm
  import sdm_pkg::*;
#(
  parameter int ACC_W  = ACC_W_DEFAULT,
  parameter int LFSR_W = LFSR_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [ACC_W-1:0] frac_word,
  input  logic             frac_load,
  output logic             frac_ack,
  input  logic             mash_mode,
  input  logic             dither_en,
  output logic             x,
  output offset_t          div_offset
);

  logic [ACC_W-1:0]  frac_act_q;
  logic              frac_ack_q;
  logic              mode_q;
  logic [LFSR_W-1:0] lfsr_q;
  logic              c2_d_q, c3_d_q, c3_dd_q;
  logic              x_q;
  offset_t           off_q;

  logic              mode_chg;
  logic              hi_run;
  logic              hi_clr;
  logic              dither_bit;
  logic              lfsr_fb;
  offset_t           y_d;

  logic [ACC_W-1:0]  stage_sum [3];
  logic              stage_carry [3];

  // A mode change clears the higher stages and delays at that same edge;
  // mode 0 keeps them parked at zero.
  assign mode_chg   = mash_mode ^ mode_q;
  assign hi_run     = enable & mash_mode & ~mode_chg;
  assign hi_clr     = ~mash_mode | mode_chg;
  assign dither_bit = dither_en & lfsr_q[0];
  assign lfsr_fb    = lfsr_q[LFSR_W-1] ^ lfsr_q[LFSR_W-1-LFSR_TAP_HI];

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        sdm_acc_stage #(.W(ACC_W)) u_stage (
          .clk      (clk),
          .rst_n    (rst_n),
          .en_i     (enable),
          .clr_i    (1'b0),
          .addend_i (frac_act_q),
          .cin_i    (dither_bit),
          .sum_o    (stage_sum[gi]),
          .carry_o  (stage_carry[gi])
        );
      end else begin : g_higher
        sdm_acc_stage #(.W(ACC_W)) u_stage (
          .clk      (clk),
          .rst_n    (rst_n),
          .en_i     (hi_run),
          .clr_i    (hi_clr),
          .addend_i (stage_sum[gi-1]),
          .cin_i    (1'b0),
          .sum_o    (stage_sum[gi]),
          .carry_o  (stage_carry[gi])
        );
      end
    end
  endgenerate

  // MASH noise cancellation; higher stages contribute nothing unless running.
  always_comb begin
    y_d = carry_to_offset(stage_carry[0]);
    if (hi_run) begin
      y_d = carry_to_offset(stage_carry[0])
          + carry_to_offset(stage_carry[1]) - carry_to_offset(c2_d_q)
          + carry_to_offset(stage_carry[2])
          - (carry_to_offset(c3_d_q) <<< 1)
          + carry_to_offset(c3_dd_q);
    end
  end

  // Carry delay line for the differentiators.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c2_d_q  <= 1'b0;
      c3_d_q  <= 1'b0;
      c3_dd_q <= 1'b0;
    end else if (hi_clr) begin
      c2_d_q  <= 1'b0;
      c3_d_q  <= 1'b0;
      c3_dd_q <= 1'b0;
    end else if (hi_run) begin
      c2_d_q  <= stage_carry[1];
      c3_dd_q <= c3_d_q;
      c3_d_q  <= stage_carry[2];
    end
  end

  // Dither LFSR advances only while dithering an enabled modulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_W'(LFSR_SEED);
    end else if (enable && dither_en) begin
      lfsr_q <= {lfsr_q[LFSR_W-2:0], lfsr_fb};
    end
  end

  // Word load (independent of enable), mode tracking and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frac_act_q <= '0;
      frac_ack_q <= 1'b0;
      mode_q     <= 1'b0;
      x_q        <= 1'b0;
      off_q      <= '0;
    end else begin
      if (frac_load) begin
        frac_act_q <= frac_word;
      end
      frac_ack_q <= frac_load;
      mode_q     <= mash_mode;
      x_q        <= enable & stage_carry[0];
      if (!enable) begin
        off_q <= '0;
      end else if (mash_mode) begin
        off_q <= y_d;
      end else begin
        off_q <= carry_to_offset(stage_carry[0]);
      end
    end
  end

  assign frac_ack   = frac_ack_q;
  assign x          = x_q;
  assign div_offset = off_q;

endmodule

// File: tb/tb_frac_n_sdm.sv
// Bench for frac_n_sdm: directed scenarios plus a randomized segment,
// every edge compared against an arithmetic reference model.
module tb_frac_n_sdm;
  import sdm_pkg::*;

  localparam int W = 16;
  localparam int M = 65536;

  logic         clk;
  logic         rst_n;
  logic         enable;
  logic [W-1:0] frac_word;
  logic         frac_load;
  logic         frac_ack;
  logic         mash_mode;
  logic         dither_en;
  logic         x;
  offset_t      div_offset;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  // reference model state
  int m_acc1, m_acc2, m_acc3, m_frac, m_lfsr;
  int m_hist2 [$];
  int m_hist3 [$];
  bit m_mode_prev;
  int m_x, m_off, m_ack;

  frac_n_sdm #(.ACC_W(W), .LFSR_W(15)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .frac_word  (frac_word),
    .frac_load  (frac_load),
    .frac_ack   (frac_ack),
    .mash_mode  (mash_mode),
    .dither_en  (dither_en),
    .x          (x),
    .div_offset (div_offset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_acc1 = 0; m_acc2 = 0; m_acc3 = 0; m_frac = 0; m_lfsr = 1;
    m_hist2 = '{0};
    m_hist3 = '{0, 0};
    m_mode_prev = 1'b0;
    m_x = 0; m_off = 0; m_ack = 0;
  endtask

  // Predicts the outputs after the coming edge from the current inputs.
  task automatic model_edge();
    int s1, s2, s3, c1, c2, c3, d, fb;
    bit chg;
    chg = (mash_mode != m_mode_prev);
    if (enable) begin
      d  = dither_en ? (m_lfsr & 1) : 0;
      s1 = m_acc1 + m_frac + d;
      c1 = s1 / M;
      m_acc1 = s1 % M;
      if (mash_mode && !chg) begin
        s2 = m_acc2 + m_acc1;  c2 = s2 / M;  m_acc2 = s2 % M;
        s3 = m_acc3 + m_acc2;  c3 = s3 / M;  m_acc3 = s3 % M;
        // first difference of c2, second difference of c3
        m_off = c1 + (c2 - m_hist2[0]) + (c3 - 2 * m_hist3[0] + m_hist3[1]);
        m_hist2 = '{c2};
        m_hist3 = '{c3, m_hist3[0]};
      end else begin
        m_acc2 = 0; m_acc3 = 0;
        m_hist2 = '{0}; m_hist3 = '{0, 0};
        m_off = c1;
      end
      m_x = c1;
      if (dither_en) begin
        fb = ((m_lfsr >> 14) ^ (m_lfsr >> 13)) & 1;
        m_lfsr = ((m_lfsr << 1) | fb) & 32'h7FFF;
      end
    end else begin
      m_x = 0; m_off = 0;
      if (chg || !mash_mode) begin
        m_acc2 = 0; m_acc3 = 0;
        m_hist2 = '{0}; m_hist3 = '{0, 0};
      end
    end
    if (frac_load) m_frac = int'(frac_word);
    m_ack = frac_load ? 1 : 0;
    m_mode_prev = mash_mode;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("x", x, m_x);
    chk("div_offset", div_offset, m_off);
    chk("frac_ack", frac_ack, m_ack);
  endtask

  initial begin
    int sum, mn, mx;
    bit outside;

    rst_n = 1'b0; enable = 1'b0; frac_word = '0; frac_load = 1'b0;
    mash_mode = 1'b0; dither_en = 1'b0;
    model_reset();
    #1;
    chk("rst_x", x, 0);
    chk("rst_off", div_offset, 0);
    chk("rst_ack", frac_ack, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: order-1 exact period with 0x4000
    frac_word = 16'h4000; frac_load = 1'b1;
    step();
    chk("t1_ack", frac_ack, 1);
    frac_load = 1'b0; enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t1_pattern", x, (i % 4 == 3) ? 1 : 0);
    end

    // 2: 0x0001 over a full accumulator period gives exactly one carry
    enable = 1'b0; frac_word = 16'h0001; frac_load = 1'b1;
    step();
    frac_load = 1'b0; enable = 1'b1;
    sum = 0;
    for (int i = 0; i < M; i++) begin
      step();
      sum += int'(x);
    end
    chk("t2_ones", sum, 1);

    // 3: MASH average and offset range
    enable = 1'b0; mash_mode = 1'b1; frac_word = 16'h8000; frac_load = 1'b1;
    step();
    frac_load = 1'b0; enable = 1'b1;
    sum = 0; mn = 0; mx = 0; outside = 1'b0;
    for (int i = 0; i < 4096; i++) begin
      step();
      sum += int'(div_offset);
      if (int'(div_offset) < mn) mn = int'(div_offset);
      if (int'(div_offset) > mx) mx = int'(div_offset);
      if (int'(div_offset) < 0 || int'(div_offset) > 1) outside = 1'b1;
    end
    chk("t3_sum_in_window", (sum >= 2045 && sum <= 2051) ? 1 : 0, 1);
    chk("t3_range", (mn >= -3 && mx <= 4) ? 1 : 0, 1);
    chk("t3_not_just_carry", int'(outside), 1);

    // 4: reload 0xC000 at cycle 100 of an order-1 run
    mash_mode = 1'b0;
    for (int i = 0; i < 100; i++) step();
    frac_word = 16'hC000; frac_load = 1'b1;
    step();
    frac_load = 1'b0;
    chk("t4_ack", frac_ack, 1);
    sum = 0;
    for (int i = 0; i < 4096; i++) begin
      step();
      sum += int'(x);
    end
    chk("t4_avg", (sum >= 3068 && sum <= 3076) ? 1 : 0, 1);

    // 5: enable gating holds state and zeroes outputs
    mash_mode = 1'b1; frac_word = 16'h2345; frac_load = 1'b1;
    step();
    frac_load = 1'b0;
    for (int i = 0; i < 20; i++) step();
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t5_x_gated", x, 0);
      chk("t5_off_gated", div_offset, 0);
    end
    enable = 1'b1;
    for (int i = 0; i < 40; i++) step();

    // randomized segment: dither, loads, mode flips, enable drops
    for (int i = 0; i < 1500; i++) begin
      enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 39) == 0) mash_mode = ~mash_mode;
      if ($urandom_range(0, 19) == 0) dither_en = ~dither_en;
      frac_load = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 5))
        0: frac_word = 16'hFFFF;
        1: frac_word = 16'h0000;
        default: frac_word = 16'($urandom);
      endcase
      step();
    end
    frac_load = 1'b0;

    // zero word, no dither: no carries at all
    enable = 1'b1; mash_mode = 1'b0; dither_en = 1'b0;
    frac_word = 16'h0000; frac_load = 1'b1;
    step();
    frac_load = 1'b0;
    step();  // word takes effect from here on
    sum = 0;
    for (int i = 0; i < 64; i++) begin
      step();
      sum += int'(x) + int'(div_offset);
    end
    chk("zero_word", sum, 0);

    // 6: asynchronous reset between edges, then restart
    mash_mode = 1'b1; dither_en = 1'b1; frac_word = 16'h9ABC; frac_load = 1'b1;
    step();
    frac_load = 1'b0;
    for (int i = 0; i < 30; i++) step();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("t6_x_async", x, 0);
    chk("t6_off_async", div_offset, 0);
    chk("t6_ack_async", frac_ack, 0);
    @(negedge clk);
    rst_n = 1'b1;
    enable = 1'b0; mash_mode = 1'b0; dither_en = 1'b0;
    frac_word = 16'h4000; frac_load = 1'b1;
    step();
    frac_load = 1'b0; enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t6_pattern", x, (i % 4 == 3) ? 1 : 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
